// File: rtl/peridot_swi_flashseq_pkg.sv
// Shared definitions for sequencers that drive the peridot_spi byte engine
// through its register +0 word (start/select/data).
package peridot_swi_flashseq_pkg;

  localparam int unsigned START_BIT = 9;
  localparam int unsigned SEL_BIT   = 8;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WAIT_FREE,
    ST_CMD,
    ST_ADDR2,
    ST_ADDR1,
    ST_ADDR0,
    ST_DATA,
    ST_HOLD,
    ST_DESEL,
    ST_DONE
  } state_t;

  // Sub-phase of every byte-issuing state: write strobe, ignored-ready guard, wait for ready.
  typedef enum logic [1:0] {
    PH_ISSUE,
    PH_GUARD,
    PH_WAIT
  } phase_t;

  function automatic logic [31:0] spi_word(input logic start, input logic sel,
                                           input logic [7:0] data);
    logic [31:0] w;
    w            = '0;
    w[START_BIT] = start;
    w[SEL_BIT]   = sel;
    w[7:0]       = data;
    return w;
  endfunction

endpackage

// File: rtl/peridot_swi_flashseq.sv
// Flash READ sequencer sharing the peridot_spi byte engine with the CPU register path;
// streams received bytes on a valid/ready port while the CPU is locked out.
module peridot_swi_flashseq
  import peridot_swi_flashseq_pkg::*;
#(
  parameter logic [7:0]  READ_CMD  = 8'h03,
  parameter int unsigned LEN_WIDTH = 16
) (
  input  logic                 clock_sig,
  input  logic                 reset_sig,
  input  logic                 cpu_write,
  input  logic [31:0]          cpu_writedata,
  output logic [31:0]          cpu_readdata,
  output logic                 cpu_locked,
  input  logic                 rd_start,
  input  logic [23:0]          rd_addr,
  input  logic [LEN_WIDTH-1:0] rd_len,
  input  logic                 rd_abort,
  output logic                 rd_busy,
  output logic                 rd_done,
  output logic [7:0]           st_data,
  output logic                 st_valid,
  input  logic                 st_ready,
  output logic                 spi_write,
  output logic [31:0]          spi_writedata,
  input  logic [31:0]          spi_readdata
);

  state_t               state, state_nxt;
  phase_t               phase, phase_nxt;
  logic [23:0]          addr_q;
  logic [LEN_WIDTH-1:0] rem_q, rem_nxt;
  logic [7:0]           rx_q, rx_nxt;
  logic                 abort_q;
  logic                 abort;
  logic                 latch;
  logic                 seq_write;
  logic [31:0]          seq_wdata;
  logic [7:0]           tx_byte;
  logic                 eng_ready;
  logic                 eng_sel;

  assign eng_ready = spi_readdata[START_BIT];
  assign eng_sel   = spi_readdata[SEL_BIT];
  assign abort     = abort_q | rd_abort;

  always_ff @(posedge clock_sig or posedge reset_sig) begin
    if (reset_sig) begin
      state   <= ST_IDLE;
      phase   <= PH_ISSUE;
      addr_q  <= '0;
      rem_q   <= '0;
      rx_q    <= '0;
      abort_q <= 1'b0;
    end else begin
      state <= state_nxt;
      phase <= phase_nxt;
      rx_q  <= rx_nxt;
      rem_q <= rem_nxt;
      if (latch) addr_q <= rd_addr;
      if (state == ST_DONE)      abort_q <= 1'b0;
      else if (rd_abort && rd_busy) abort_q <= 1'b1;
    end
  end

  always_comb begin
    unique case (state)
      ST_CMD:   tx_byte = READ_CMD;
      ST_ADDR2: tx_byte = addr_q[23:16];
      ST_ADDR1: tx_byte = addr_q[15:8];
      ST_ADDR0: tx_byte = addr_q[7:0];
      default:  tx_byte = 8'h00;
    endcase
  end

  always_comb begin
    state_nxt = state;
    phase_nxt = phase;
    rem_nxt   = rem_q;
    rx_nxt    = rx_q;
    latch     = 1'b0;
    seq_write = 1'b0;
    seq_wdata = '0;
    case (state)
      ST_IDLE, ST_DONE: begin
        phase_nxt = PH_ISSUE;
        state_nxt = ST_IDLE;
        if (rd_start) begin
          latch     = 1'b1;
          rem_nxt   = rd_len;
          state_nxt = ST_WAIT_FREE;
        end
      end
      ST_WAIT_FREE: begin
        // A CPU write in the same cycle may be opening a transaction, so it wins.
        if (abort) state_nxt = ST_DONE;
        else if (eng_ready && !eng_sel && !cpu_write) begin
          state_nxt = ST_CMD;
          phase_nxt = PH_ISSUE;
        end
      end
      ST_CMD, ST_ADDR2, ST_ADDR1, ST_ADDR0, ST_DATA: begin
        case (phase)
          PH_ISSUE: begin
            if (abort) state_nxt = ST_DESEL;
            else begin
              seq_write = 1'b1;
              seq_wdata = spi_word(1'b1, 1'b1, tx_byte);
              phase_nxt = PH_GUARD;
            end
          end
          PH_GUARD: phase_nxt = PH_WAIT;
          default: begin
            if (eng_ready) begin
              phase_nxt = PH_ISSUE;
              if (abort) state_nxt = ST_DESEL;
              else begin
                case (state)
                  ST_CMD:   state_nxt = ST_ADDR2;
                  ST_ADDR2: state_nxt = ST_ADDR1;
                  ST_ADDR1: state_nxt = ST_ADDR0;
                  ST_ADDR0: state_nxt = (rem_q == '0) ? ST_DESEL : ST_DATA;
                  default: begin
                    rx_nxt    = spi_readdata[7:0];
                    state_nxt = ST_HOLD;
                  end
                endcase
              end
            end
          end
        endcase
      end
      ST_HOLD: begin
        phase_nxt = PH_ISSUE;
        if (abort) state_nxt = ST_DESEL;
        else if (st_ready) begin
          rem_nxt   = rem_q - LEN_WIDTH'(1);
          state_nxt = (rem_q == LEN_WIDTH'(1)) ? ST_DESEL : ST_DATA;
        end
      end
      ST_DESEL: begin
        seq_write = 1'b1;
        seq_wdata = spi_word(1'b0, 1'b0, 8'h00);
        state_nxt = ST_DONE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign cpu_locked = (state == ST_CMD)  || (state == ST_ADDR2) || (state == ST_ADDR1) ||
                      (state == ST_ADDR0) || (state == ST_DATA) || (state == ST_HOLD) ||
                      (state == ST_DESEL);
  assign rd_busy    = (state != ST_IDLE) && (state != ST_DONE);
  assign rd_done    = (state == ST_DONE);
  assign st_valid   = (state == ST_HOLD) && !abort;
  assign st_data    = rx_q;

  assign spi_write     = cpu_locked ? seq_write : cpu_write;
  assign spi_writedata = cpu_locked ? seq_wdata : cpu_writedata;

  always_comb begin
    cpu_readdata = spi_readdata;
    if (cpu_locked) cpu_readdata[START_BIT] = 1'b0;
  end

endmodule

// File: tb/tb_peridot_swi_flashseq.sv
// Bench for peridot_swi_flashseq: behavioural byte engine + SPI flash, stream scoreboard.
module tb_peridot_swi_flashseq;

  logic        clock_sig = 1'b0;
  logic        reset_sig = 1'b1;
  logic        cpu_write = 1'b0;
  logic [31:0] cpu_writedata = '0;
  logic [31:0] cpu_readdata;
  logic        cpu_locked;
  logic        rd_start = 1'b0;
  logic [23:0] rd_addr = '0;
  logic [15:0] rd_len = '0;
  logic        rd_abort = 1'b0;
  logic        rd_busy;
  logic        rd_done;
  logic [7:0]  st_data;
  logic        st_valid;
  logic        st_ready = 1'b0;
  logic        spi_write;
  logic [31:0] spi_writedata;
  logic [31:0] spi_readdata;

  int checks = 0;
  int fails  = 0;

  peridot_swi_flashseq #(.READ_CMD(8'h03), .LEN_WIDTH(16)) dut (
    .clock_sig(clock_sig), .reset_sig(reset_sig),
    .cpu_write(cpu_write), .cpu_writedata(cpu_writedata),
    .cpu_readdata(cpu_readdata), .cpu_locked(cpu_locked),
    .rd_start(rd_start), .rd_addr(rd_addr), .rd_len(rd_len), .rd_abort(rd_abort),
    .rd_busy(rd_busy), .rd_done(rd_done),
    .st_data(st_data), .st_valid(st_valid), .st_ready(st_ready),
    .spi_write(spi_write), .spi_writedata(spi_writedata), .spi_readdata(spi_readdata)
  );

  always #5 clock_sig = ~clock_sig;

  function automatic logic [7:0] flash_byte(input logic [23:0] a);
    logic [7:0] t;
    t = a[7:0] * 8'd13;
    return t ^ a[15:8] ^ {a[20:16], 3'b101};
  endfunction

  // Byte engine + flash model: a start write makes ready drop for 1-4 cycles.
  logic        e_ready, e_sel;
  logic [7:0]  e_rx, e_tx;
  int          e_cnt, e_idx;
  logic [23:0] f_addr;
  logic [7:0]  mosi_q[$];
  logic [7:0]  rx_got[$];
  int xfers = 0, desel_cnt = 0, hs_cnt = 0, done_cnt = 0, stv_cnt = 0;

  assign spi_readdata = {22'b0, e_ready, e_sel, e_rx};

  always @(posedge clock_sig or posedge reset_sig) begin
    if (reset_sig) begin
      e_ready <= 1'b1; e_sel <= 1'b0; e_rx <= '0; e_tx <= '0;
      e_cnt <= 0; e_idx <= 0; f_addr <= '0;
    end else if (spi_write) begin
      e_sel <= spi_writedata[8];
      if (!spi_writedata[8]) e_idx <= 0;
      if (spi_writedata[9] && e_ready) begin
        e_ready <= 1'b0;
        e_cnt   <= int'($urandom_range(1, 4));
        e_tx    <= spi_writedata[7:0];
        mosi_q.push_back(spi_writedata[7:0]);
        xfers   <= xfers + 1;
      end
      if (spi_writedata[9:8] == 2'b00) desel_cnt <= desel_cnt + 1;
    end else if (!e_ready) begin
      if (e_cnt <= 1) begin
        e_ready <= 1'b1;
        e_idx   <= e_idx + 1;
        case (e_idx)
          1: f_addr[23:16] <= e_tx;
          2: f_addr[15:8]  <= e_tx;
          3: f_addr[7:0]   <= e_tx;
          default: ;
        endcase
        e_rx <= (e_idx >= 4) ? flash_byte(f_addr + 24'(e_idx - 4)) : 8'h00;
      end else e_cnt <= e_cnt - 1;
    end
  end

  always @(posedge clock_sig) begin
    if (!reset_sig) begin
      if (st_valid && st_ready) begin
        rx_got.push_back(st_data);
        hs_cnt <= hs_cnt + 1;
      end
      if (st_valid) stv_cnt <= stv_cnt + 1;
      if (rd_done) done_cnt <= done_cnt + 1;
    end
  end

  task automatic tick();
    @(negedge clock_sig);
  endtask

  task automatic start_req(input logic [23:0] addr, input int len);
    rd_addr  = addr;
    rd_len   = 16'(len);
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
  endtask

  task automatic wait_done(input int limit, input int mode, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      st_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      tick();
      if (rd_done) begin ok = 1'b1; break; end
    end
    st_ready = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    tick();
    checks++; if ({rd_busy, rd_done, st_valid, cpu_locked, spi_write} !== 5'b0)
      begin fails++; $display("FAIL reset_ctrl got=%b want=00000", {rd_busy, rd_done, st_valid, cpu_locked, spi_write}); end
    checks++; if (st_data !== 8'h00)
      begin fails++; $display("FAIL reset_st_data got=%h want=00", st_data); end
    checks++; if (spi_writedata !== 32'h0)
      begin fails++; $display("FAIL reset_wdata got=%h want=0", spi_writedata); end
    reset_sig = 1'b0;
    repeat (4) tick();
    checks++; if (spi_write !== 1'b0 || xfers != 0)
      begin fails++; $display("FAIL post_reset_strobe got=%b/%0d want=0/0", spi_write, xfers); end
  endtask

  task automatic test_basic(input logic [23:0] addr, input int len, input int mode);
    bit ok;
    int db;
    logic [7:0] exp_hdr[4];
    mosi_q.delete(); rx_got.delete();
    db = done_cnt;
    exp_hdr[0] = 8'h03; exp_hdr[1] = addr[23:16]; exp_hdr[2] = addr[15:8]; exp_hdr[3] = addr[7:0];
    start_req(addr, len);
    wait_done(4000, mode, ok);
    checks++; if (!ok) begin fails++; $display("FAIL basic_timeout got=no_done want=done"); end
    checks++; if (mosi_q.size() != 4 + len)
      begin fails++; $display("FAIL basic_mosi_count got=%0d want=%0d", mosi_q.size(), 4 + len); end
    for (int i = 0; i < 4 && i < mosi_q.size(); i++) begin
      checks++; if (mosi_q[i] !== exp_hdr[i])
        begin fails++; $display("FAIL basic_mosi[%0d] got=%h want=%h", i, mosi_q[i], exp_hdr[i]); end
    end
    checks++; if (rx_got.size() != len)
      begin fails++; $display("FAIL basic_rx_count got=%0d want=%0d", rx_got.size(), len); end
    for (int i = 0; i < len && i < rx_got.size(); i++) begin
      checks++; if (rx_got[i] !== flash_byte(addr + 24'(i)))
        begin fails++; $display("FAIL basic_rx[%0d] got=%h want=%h", i, rx_got[i], flash_byte(addr + 24'(i))); end
    end
    checks++; if (done_cnt - db != 1)
      begin fails++; $display("FAIL basic_done_pulses got=%0d want=1", done_cnt - db); end
    checks++; if ({cpu_locked, rd_busy, e_sel} !== 3'b000)
      begin fails++; $display("FAIL basic_idle lock/busy/sel got=%b want=000", {cpu_locked, rd_busy, e_sel}); end
  endtask

  task automatic test_backpressure();
    int stall;
    bit got_done;
    logic [7:0] held;
    logic [23:0] addr;
    mosi_q.delete(); rx_got.delete();
    addr = 24'($urandom);
    stall = 0; got_done = 0; held = '0;
    start_req(addr, 3);
    for (int c = 0; c < 3000; c++) begin
      if (rd_done) begin got_done = 1; break; end
      if (stall > 0) begin
        checks++; if (st_valid !== 1'b1 || st_data !== held)
          begin fails++; $display("FAIL stall_hold got=%b/%h want=1/%h", st_valid, st_data, held); end
        checks++; if (spi_write !== 1'b0)
          begin fails++; $display("FAIL stall_write got=%b want=0", spi_write); end
      end
      if (st_valid) begin
        if (stall == 0) held = st_data;
        if (stall < 20) begin st_ready = 1'b0; stall++; end
        else begin st_ready = 1'b1; stall = 0; end
      end else begin
        st_ready = 1'b0; stall = 0;
      end
      tick();
    end
    st_ready = 1'b0;
    tick();
    checks++; if (!got_done) begin fails++; $display("FAIL bp_timeout got=no_done want=done"); end
    checks++; if (rx_got.size() != 3 || mosi_q.size() != 7)
      begin fails++; $display("FAIL bp_counts got=%0d/%0d want=3/7", rx_got.size(), mosi_q.size()); end
    for (int i = 0; i < rx_got.size(); i++) begin
      checks++; if (rx_got[i] !== flash_byte(addr + 24'(i)))
        begin fails++; $display("FAIL bp_rx[%0d] got=%h want=%h", i, rx_got[i], flash_byte(addr + 24'(i))); end
    end
  endtask

  task automatic test_cpu_contention();
    bit ok;
    bit locked_seen;
    mosi_q.delete(); rx_got.delete();
    cpu_writedata = 32'h100; cpu_write = 1'b1; tick(); cpu_write = 1'b0;
    start_req(24'hABCDEF, 2);
    repeat (20) tick();
    checks++; if ({rd_busy, cpu_locked} !== 2'b10 || mosi_q.size() != 0)
      begin fails++; $display("FAIL wait_free busy/lock=%b mosi=%0d want=10/0", {rd_busy, cpu_locked}, mosi_q.size()); end
    cpu_writedata = 32'h000; cpu_write = 1'b1; tick(); cpu_write = 1'b0;
    locked_seen = 0;
    for (int i = 0; i < 50; i++) begin
      if (cpu_locked) begin locked_seen = 1; break; end
      tick();
    end
    checks++; if (!locked_seen) begin fails++; $display("FAIL lock_timeout got=0 want=1"); end
    cpu_writedata = 32'h2AA; cpu_write = 1'b1;
    #1;
    checks++; if (spi_writedata === 32'h2AA)
      begin fails++; $display("FAIL locked_passthrough got=%h want=!2aa", spi_writedata); end
    checks++; if (cpu_readdata[9] !== 1'b0)
      begin fails++; $display("FAIL locked_ready_mask got=%b want=0", cpu_readdata[9]); end
    tick(); cpu_write = 1'b0; cpu_writedata = '0;
    wait_done(2000, 0, ok);
    checks++; if (!ok || mosi_q.size() != 6 || rx_got.size() != 2)
      begin fails++; $display("FAIL cont_result ok=%0d mosi=%0d rx=%0d want=1/6/2", ok, mosi_q.size(), rx_got.size()); end
    checks++; if (mosi_q.size() > 0 && mosi_q[0] !== 8'h03)
      begin fails++; $display("FAIL cont_cmd got=%h want=03", mosi_q[0]); end
  endtask

  task automatic test_len_zero();
    bit ok;
    int sb, db, xb;
    mosi_q.delete(); rx_got.delete();
    sb = stv_cnt; db = desel_cnt; xb = done_cnt;
    start_req(24'h000000, 0);
    wait_done(2000, 0, ok);
    checks++; if (!ok || mosi_q.size() != 4)
      begin fails++; $display("FAIL len0_mosi ok=%0d count=%0d want=1/4", ok, mosi_q.size()); end
    checks++; if (mosi_q.size() == 4 && {mosi_q[0], mosi_q[1], mosi_q[2], mosi_q[3]} !== 32'h03000000)
      begin fails++; $display("FAIL len0_bytes got=%h%h%h%h want=03000000", mosi_q[0], mosi_q[1], mosi_q[2], mosi_q[3]); end
    checks++; if (stv_cnt != sb)
      begin fails++; $display("FAIL len0_st_valid got=%0d want=0", stv_cnt - sb); end
    checks++; if (desel_cnt - db != 1 || done_cnt - xb != 1 || e_sel !== 1'b0)
      begin fails++; $display("FAIL len0_desel desel=%0d done=%0d sel=%b want=1/1/0", desel_cnt - db, done_cnt - xb, e_sel); end
  endtask

  task automatic test_abort();
    bit ok, reached;
    int hb, sb, db, xb;
    mosi_q.delete(); rx_got.delete();
    hb = hs_cnt; sb = stv_cnt; db = done_cnt;
    start_req(24'h055AA0, 8);
    reached = 0;
    for (int i = 0; i < 2000; i++) begin
      st_ready = 1'b1;
      if (hs_cnt - hb == 2) begin reached = 1; break; end
      tick();
    end
    checks++; if (!reached) begin fails++; $display("FAIL abort_reach got=%0d want=2", hs_cnt - hb); end
    rd_abort = 1'b1; xb = xfers;
    tick();
    rd_abort = 1'b0;
    wait_done(2000, 0, ok);
    checks++; if (!ok) begin fails++; $display("FAIL abort_timeout got=no_done want=done"); end
    checks++; if (hs_cnt - hb != 2 || stv_cnt - sb != 2)
      begin fails++; $display("FAIL abort_stream hs=%0d valid=%0d want=2/2", hs_cnt - hb, stv_cnt - sb); end
    checks++; if (xfers - xb > 1)
      begin fails++; $display("FAIL abort_xfers got=%0d want<=1", xfers - xb); end
    checks++; if ({e_sel, rd_busy, cpu_locked} !== 3'b000 || done_cnt - db != 1)
      begin fails++; $display("FAIL abort_end sel/busy/lock=%b done=%0d want=000/1", {e_sel, rd_busy, cpu_locked}, done_cnt - db); end
  endtask

  task automatic test_reset_mid();
    bit reached;
    mosi_q.delete(); rx_got.delete();
    start_req(24'h123456, 4);
    reached = 0;
    for (int i = 0; i < 500; i++) begin
      if (mosi_q.size() >= 3) begin reached = 1; break; end
      tick();
    end
    checks++; if (!reached) begin fails++; $display("FAIL rstmid_reach got=%0d want=3", mosi_q.size()); end
    tick();
    reset_sig = 1'b1;
    #1;
    checks++; if ({rd_busy, rd_done, st_valid, cpu_locked, spi_write} !== 5'b0 || st_data !== 8'h00)
      begin fails++; $display("FAIL rstmid_outputs got=%b/%h want=00000/00", {rd_busy, rd_done, st_valid, cpu_locked, spi_write}, st_data); end
    tick();
    reset_sig = 1'b0;
    tick();
    test_basic(24'h123456, 4, 0);
  endtask

  initial begin
    test_reset();
    test_basic(24'h012345, 4, 0);
    test_backpressure();
    test_cpu_contention();
    test_len_zero();
    test_abort();
    test_reset_mid();
    for (int n = 0; n < 6; n++)
      test_basic(24'($urandom), int'($urandom_range(0, 6)), int'($urandom_range(0, 1)));
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
